// File: rtl/eth_miim_cmdq_pkg.sv
// Shared types and defaults for the MIIM command queue: FSM states, command word layout.
package eth_miim_cmdq_pkg;

    localparam int FIAD_W          = 5;
    localparam int RGAD_W          = 5;
    localparam int DATA_W          = 16;
    localparam int TIMER_W         = 16;
    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // 27-bit command word: {Write, Fiad, Rgad, Data}
    typedef struct packed {
        logic              write;
        logic [FIAD_W-1:0] fiad;
        logic [RGAD_W-1:0] rgad;
        logic [DATA_W-1:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/eth_miim_cmdfifo.sv
// Synchronous command FIFO with wrapping pointers and an occupancy counter.
module eth_miim_cmdfifo
    import eth_miim_cmdq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   push,
    input  cmd_t                   wdata,
    input  logic                   pop,
    output cmd_t                   rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;
    cmd_t          mem_q [DEPTH];

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/eth_miim_cmdq.sv
// MIIM command queue: buffers host commands, issues them one at a time to eth_miim
// and returns one response per command, with a timeout against a stuck controller.
module eth_miim_cmdq
    import eth_miim_cmdq_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   CmdValid,
    output logic                   CmdReady,
    input  logic                   CmdWrite,
    input  logic [FIAD_W-1:0]      CmdFiad,
    input  logic [RGAD_W-1:0]      CmdRgad,
    input  logic [DATA_W-1:0]      CmdData,
    output logic                   RspValid,
    input  logic                   RspReady,
    output logic [DATA_W-1:0]      RspData,
    output logic                   RspErr,
    output logic                   RspLinkFail,
    output logic [$clog2(DEPTH):0] QueueLevel,
    output logic                   MiimWCtrlData,
    output logic                   MiimRStat,
    output logic [FIAD_W-1:0]      MiimFiad,
    output logic [RGAD_W-1:0]      MiimRgad,
    output logic [DATA_W-1:0]      MiimCtrlData,
    input  logic                   MiimBusy,
    input  logic                   MiimWCtrlDataStart,
    input  logic                   MiimRStatStart,
    input  logic                   MiimUpdateRxData,
    input  logic [DATA_W-1:0]      MiimPrsd,
    input  logic                   MiimLinkFail
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);

    cmd_t fifo_rdata;
    cmd_t cmd_in;
    logic fifo_pop, fifo_full, fifo_empty;

    assign cmd_in   = '{write: CmdWrite, fiad: CmdFiad, rgad: CmdRgad, data: CmdData};
    assign CmdReady = !fifo_full;

    eth_miim_cmdfifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk    (Clk),
        .Resetn (Resetn),
        .push   (CmdValid),
        .wdata  (cmd_in),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .level  (QueueLevel),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                wctrl_q, wctrl_d;
    logic                rstat_q, rstat_d;
    logic [FIAD_W-1:0]   fiad_q, fiad_d;
    logic [RGAD_W-1:0]   rgad_q, rgad_d;
    logic [DATA_W-1:0]   ctrl_data_q, ctrl_data_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                rdcap_q, rdcap_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                rsp_link_q, rsp_link_d;
    logic                enter_resp, resp_err;
    logic [DATA_W-1:0]   resp_data;
    logic                timed_out;

    assign timed_out = (timer_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wctrl_d     = wctrl_q;
        rstat_d     = rstat_q;
        fiad_d      = fiad_q;
        rgad_d      = rgad_q;
        ctrl_data_d = ctrl_data_q;
        timer_d     = timer_q;
        rdcap_d     = rdcap_q;
        rd_data_d   = rd_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_link_d  = rsp_link_q;
        fifo_pop    = 1'b0;
        enter_resp  = 1'b0;
        resp_err    = 1'b0;
        resp_data   = '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    write_d     = fifo_rdata.write;
                    fiad_d      = fifo_rdata.fiad;
                    rgad_d      = fifo_rdata.rgad;
                    ctrl_data_d = fifo_rdata.data;
                    wctrl_d     = fifo_rdata.write;
                    rstat_d     = !fifo_rdata.write;
                    timer_d     = '0;
                    rdcap_d     = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + TIMER_W'(1);
                if (write_q ? MiimWCtrlDataStart : MiimRStatStart) begin
                    wctrl_d = 1'b0;
                    rstat_d = 1'b0;
                    state_d = ST_WAIT;
                end else if (timed_out) begin
                    wctrl_d    = 1'b0;
                    rstat_d    = 1'b0;
                    enter_resp = 1'b1;
                    resp_err   = 1'b1;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (MiimUpdateRxData) begin
                    rd_data_d = MiimPrsd;
                    rdcap_d   = 1'b1;
                end
                // Read data arriving in the same cycle Busy falls is forwarded directly.
                if (!MiimBusy && (write_q || rdcap_q || MiimUpdateRxData)) begin
                    enter_resp = 1'b1;
                    if (!write_q) resp_data = MiimUpdateRxData ? MiimPrsd : rd_data_q;
                end else if (timed_out) begin
                    enter_resp = 1'b1;
                    resp_err   = 1'b1;
                end
            end
            ST_RESP: begin
                if (RspReady) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    rsp_link_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = resp_data;
            rsp_err_d   = resp_err;
            rsp_link_d  = MiimLinkFail;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            wctrl_q     <= 1'b0;
            rstat_q     <= 1'b0;
            fiad_q      <= '0;
            rgad_q      <= '0;
            ctrl_data_q <= '0;
            timer_q     <= '0;
            rdcap_q     <= 1'b0;
            rd_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_link_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            wctrl_q     <= wctrl_d;
            rstat_q     <= rstat_d;
            fiad_q      <= fiad_d;
            rgad_q      <= rgad_d;
            ctrl_data_q <= ctrl_data_d;
            timer_q     <= timer_d;
            rdcap_q     <= rdcap_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_link_q  <= rsp_link_d;
        end
    end

    assign MiimWCtrlData = wctrl_q;
    assign MiimRStat     = rstat_q;
    assign MiimFiad      = fiad_q;
    assign MiimRgad      = rgad_q;
    assign MiimCtrlData  = ctrl_data_q;
    assign RspValid      = rsp_valid_q;
    assign RspData       = rsp_data_q;
    assign RspErr        = rsp_err_q;
    assign RspLinkFail   = rsp_link_q;

endmodule
